prefix_adder_pipe: RTL

PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

---
 rtl/prefix_adder_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prefix_adder_pipe.sv
// Two-stage pipelined Kogge-Stone adder/subtractor with valid/ready handshaking
// and a chained carry/zero register so ADDC/SUBC can extend operations across beats.
module prefix_adder_pipe #(
    parameter int   WIDTH      = 32,
    parameter logic CARRY_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int LEVELS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBC = 2'b11
    } op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;

    logic             carry_q;
    logic             zero_q;

    logic             out_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] b_eff;

    logic             carry_in;
    logic [WIDTH-1:0] g_seed;
    logic [WIDTH-1:0] group_g;
    logic [WIDTH-1:0] carries;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;
    logic             zero_next;

    // Kogge-Stone: each level combines (G,P) with the group 2^lvl positions below.
    function automatic logic [WIDTH-1:0] prefix_generate(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        gg = g;
        pp = p;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            gn = gg;
            pn = pp;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << lvl)) begin
                    gn[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
                    pn[i] = pp[i] & pp[i - (1 << lvl)];
                end
            end
            gg = gn;
            pp = pn;
        end
        return gg;
    endfunction

    assign out_adv  = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || out_adv;
    assign in_ready = rst_n && s1_adv;
    assign b_eff    = in_op[0] ? ~in_b : in_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s1_g     <= '0;
            s1_p     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= b_eff;
                s1_op <= op_e'(in_op);
                s1_g  <= in_a & b_eff;
                s1_p  <= in_a ^ b_eff;
            end
        end
    end

    // Carry-in is folded into bit 0's generate so the tree yields carries including it.
    always_comb begin
        case (s1_op)
            OP_ADD:  carry_in = 1'b0;
            OP_SUB:  carry_in = 1'b1;
            default: carry_in = carry_q;
        endcase
        g_seed    = s1_g;
        g_seed[0] = s1_g[0] | (s1_p[0] & carry_in);
        group_g   = prefix_generate(g_seed, s1_p);
        carries   = {group_g[WIDTH-2:0], carry_in};
        sum_next  = s1_a ^ s1_b ^ carries;
        cout_next = group_g[WIDTH-1];
        ovf_next  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_next[WIDTH-1] != s1_a[WIDTH-1]);
        zero_next = (sum_next == '0) && (s1_op[1] ? zero_q : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            carry_q   <= CARRY_INIT;
            zero_q    <= 1'b1;
        end else if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_next;
                out_cout <= cout_next;
                out_ovf  <= ovf_next;
                out_zero <= zero_next;
                carry_q  <= cout_next;
                zero_q   <= zero_next;
            end
        end
    end

endmodule
